// File: rtl/card_reader_converter_pkg.sv
// Shared constants and types for the punch-card row reader and BCD-to-binary converter.
package card_reader_converter_pkg;

  localparam int ROWS_DEFAULT  = 15;
  localparam int ACC_W_DEFAULT = 50;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // LSB position of each BCD field inside a 16-bit row word
  localparam int FLD_X = 12;
  localparam int FLD_Y = 8;
  localparam int FLD_Z = 4;
  localparam int FLD_B = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ACC   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CARD_EQ1 = 2'd1;
  localparam logic [1:0] CARD_EQ2 = 2'd2;
  localparam logic [1:0] CARD_EQ3 = 2'd3;

  function automatic logic is_bcd_digit(input logic [3:0] nibble);
    return (nibble <= 4'd9);
  endfunction

endpackage

// File: rtl/card_reader_converter_bcd_mac_lane.sv
// One field lane: folds decimal digits into a binary accumulator (acc*10 + digit),
// with sticky flags for non-digit codes and for results wider than ACC_W.
module card_reader_converter_bcd_mac_lane
  import card_reader_converter_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [3:0]       i_nibble,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_err,
  output logic             o_ovf
);

  logic [ACC_W-1:0] r_acc;
  logic             r_err;
  logic             r_ovf;
  logic [ACC_W+3:0] w_wide;
  logic [ACC_W+3:0] w_sum;
  logic             w_digit;

  // acc*10 + digit, carried at four extra bits so overflow is visible
  always_comb begin
    w_wide  = {4'b0000, r_acc};
    w_sum   = (w_wide << 3) + (w_wide << 1) + {{ACC_W{1'b0}}, i_nibble};
    w_digit = is_bcd_digit(i_nibble);
  end

  // Accumulator and sticky flags; blank nibbles leave everything untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= {ACC_W{1'b0}};
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_acc <= {ACC_W{1'b0}};
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      if (w_digit) begin
        r_acc <= w_sum[ACC_W-1:0];
        if (|w_sum[ACC_W+3:ACC_W]) begin
          r_ovf <= 1'b1;
        end
      end else if (i_nibble != BLANK_DIGIT) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_acc = r_acc;
  assign o_err = r_err;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/card_reader_converter.sv
// Reads one equation card row by row from the punch-card ROM and converts the
// four BCD fields (X, Y, Z, B) to binary, most significant row first.
module card_reader_converter
  import card_reader_converter_pkg::*;
#(
  parameter int ROWS  = ROWS_DEFAULT,
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       card_sel,
  output logic             busy,
  output logic             done,
  output logic             bad_sel,
  output logic [1:0]       card_slt,
  output logic             mask,
  output logic [3:0]       card_addr,
  input  logic [15:0]      card_in,
  output logic [ACC_W-1:0] val_x,
  output logic [ACC_W-1:0] val_y,
  output logic [ACC_W-1:0] val_z,
  output logic [ACC_W-1:0] val_b,
  output logic [3:0]       digit_err,
  output logic [3:0]       ovf
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_e      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_bad_sel;
  logic [1:0]  r_card_slt;
  logic [3:0]  r_card_addr;
  logic [15:0] r_row;
  logic        w_accept;
  logic        w_acc_en;
  logic [3:0]  w_err;
  logic [3:0]  w_ovf;

  assign w_accept = (r_state == IDLE) && start && (card_sel != 2'd0);
  assign w_acc_en = (r_state == ACC);

  // Card sequencer: one FETCH/ACC pair per row, then a single DONE cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bad_sel   <= 1'b0;
      r_card_slt  <= 2'd0;
      r_card_addr <= 4'd0;
      r_row       <= 16'd0;
    end else begin
      r_done    <= 1'b0;
      r_bad_sel <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (card_sel != 2'd0) begin
              r_card_slt  <= card_sel;
              r_card_addr <= 4'd0;
              r_busy      <= 1'b1;
              r_state     <= FETCH;
            end else begin
              r_bad_sel <= 1'b1;
            end
          end
        end
        FETCH: begin
          r_row   <= card_in;
          r_state <= ACC;
        end
        ACC: begin
          if (r_card_addr == LAST_ROW) begin
            r_state <= DONE;
          end else begin
            r_card_addr <= r_card_addr + 4'd1;
            r_state     <= FETCH;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  card_reader_converter_bcd_mac_lane #(.ACC_W(ACC_W)) u_lane_x (
    .clk(clk), .rst_n(rst_n), .i_clear(w_accept), .i_en(w_acc_en),
    .i_nibble(r_row[FLD_X +: 4]), .o_acc(val_x), .o_err(w_err[3]), .o_ovf(w_ovf[3])
  );

  card_reader_converter_bcd_mac_lane #(.ACC_W(ACC_W)) u_lane_y (
    .clk(clk), .rst_n(rst_n), .i_clear(w_accept), .i_en(w_acc_en),
    .i_nibble(r_row[FLD_Y +: 4]), .o_acc(val_y), .o_err(w_err[2]), .o_ovf(w_ovf[2])
  );

  card_reader_converter_bcd_mac_lane #(.ACC_W(ACC_W)) u_lane_z (
    .clk(clk), .rst_n(rst_n), .i_clear(w_accept), .i_en(w_acc_en),
    .i_nibble(r_row[FLD_Z +: 4]), .o_acc(val_z), .o_err(w_err[1]), .o_ovf(w_ovf[1])
  );

  card_reader_converter_bcd_mac_lane #(.ACC_W(ACC_W)) u_lane_b (
    .clk(clk), .rst_n(rst_n), .i_clear(w_accept), .i_en(w_acc_en),
    .i_nibble(r_row[FLD_B +: 4]), .o_acc(val_b), .o_err(w_err[0]), .o_ovf(w_ovf[0])
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign bad_sel   = r_bad_sel;
  assign card_slt  = r_card_slt;
  assign card_addr = r_card_addr;
  assign mask      = 1'b0;
  assign digit_err = w_err;
  assign ovf       = w_ovf;

endmodule

// File: tb/tb_card_reader_converter.sv
// Table-driven bench with a done-triggered scoreboard for card_reader_converter.
module tb_card_reader_converter;

  localparam int ACC_W = 50;

  typedef struct {
    logic [1:0]       sel;
    logic [15:0]      r0, r1, r2, r3, fill;
    logic [ACC_W-1:0] ex, ey, ez, eb;
    logic [3:0]       eerr, eovf;
  } vec_t;

  typedef struct {
    logic [ACC_W-1:0] x, y, z, b;
    logic [3:0]       err, ovf;
    int               scyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start;
  logic [1:0] card_sel, card_slt;
  logic busy, done, bad_sel, mask;
  logic [3:0] card_addr, digit_err, ovf;
  logic [15:0] card_in;
  logic [ACC_W-1:0] val_x, val_y, val_z, val_b;
  logic [15:0] rom [4][16];

  logic start8;
  logic [1:0] card_sel8, card_slt8;
  logic busy8, done8, bad_sel8, mask8;
  logic [3:0] card_addr8, digit_err8, ovf8;
  logic [15:0] card_in8;
  logic [7:0] val_x8, val_y8, val_z8, val_b8;
  logic [15:0] rom8 [16];

  assign card_in  = rom[card_slt][card_addr];
  assign card_in8 = rom8[card_addr8];

  card_reader_converter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .card_sel(card_sel),
    .busy(busy), .done(done), .bad_sel(bad_sel), .card_slt(card_slt),
    .mask(mask), .card_addr(card_addr), .card_in(card_in),
    .val_x(val_x), .val_y(val_y), .val_z(val_z), .val_b(val_b),
    .digit_err(digit_err), .ovf(ovf)
  );

  card_reader_converter #(.ROWS(15), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .card_sel(card_sel8),
    .busy(busy8), .done(done8), .bad_sel(bad_sel8), .card_slt(card_slt8),
    .mask(mask8), .card_addr(card_addr8), .card_in(card_in8),
    .val_x(val_x8), .val_y(val_y8), .val_z(val_z8), .val_b(val_b8),
    .digit_err(digit_err8), .ovf(ovf8)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [15:0] seen_addr;
  logic mask_bad;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pops one expected result
  always @(posedge clk) begin
    #1;
    if (busy === 1'b1) seen_addr[card_addr] = 1'b1;
    if (mask !== 1'b0 || mask8 !== 1'b0) mask_bad = 1'b1;
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("val_x", 64'(val_x), 64'(mon_e.x));
        chk("val_y", 64'(val_y), 64'(mon_e.y));
        chk("val_z", 64'(val_z), 64'(mon_e.z));
        chk("val_b", 64'(val_b), 64'(mon_e.b));
        chk("digit_err", 64'(digit_err), 64'(mon_e.err));
        chk("ovf", 64'(ovf), 64'(mon_e.ovf));
        chk("done_latency", 64'(cyc - mon_e.scyc), 64'd31);
      end
    end
  end

  task automatic load_rom(input vec_t v);
    for (int a = 0; a < 4; a++)
      for (int r = 0; r < 16; r++)
        rom[a][r] = 16'h1357;
    for (int r = 0; r < 16; r++) rom[v.sel][r] = v.fill;
    rom[v.sel][0] = v.r0;
    rom[v.sel][1] = v.r1;
    rom[v.sel][2] = v.r2;
    rom[v.sel][3] = v.r3;
  endtask

  task automatic start_run(input vec_t v);
    exp_t e;
    @(negedge clk);
    card_sel = v.sel;
    start = 1'b1;
    seen_addr = 16'd0;
    mask_bad = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.x = v.ex; e.y = v.ey; e.z = v.ez; e.b = v.eb;
    e.err = v.eerr; e.ovf = v.eovf; e.scyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 60 && sbq.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    chk({tag, "_done_seen"}, 64'(sbq.size()), 64'd0);
    chk({tag, "_addr_sweep"}, 64'(seen_addr), 64'h7FFF);
    chk({tag, "_mask_low"}, {63'd0, mask_bad}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev_addr;
    int k8;

    tbl[0] = '{sel:2'd1, r0:16'h1234, r1:16'h5F09, r2:16'hFFFF, r3:16'hFFFF, fill:16'hFFFF,
               ex:50'd15, ey:50'd2, ez:50'd30, eb:50'd49, eerr:4'b0000, eovf:4'b0000};
    tbl[1] = '{sel:2'd2, r0:16'hFFFF, r1:16'hFFFF, r2:16'hFFFF, r3:16'hCFFF, fill:16'hFFFF,
               ex:50'd0, ey:50'd0, ez:50'd0, eb:50'd0, eerr:4'b1000, eovf:4'b0000};
    tbl[2] = '{sel:2'd3, r0:16'h9876, r1:16'h0000, r2:16'h1FFF, r3:16'hFFFF, fill:16'hFFFF,
               ex:50'd901, ey:50'd80, ez:50'd70, eb:50'd60, eerr:4'b0000, eovf:4'b0000};
    tbl[3] = '{sel:2'd1, r0:16'hABDE, r1:16'h1234, r2:16'hFFFF, r3:16'hFFFF, fill:16'hFFFF,
               ex:50'd1, ey:50'd2, ez:50'd3, eb:50'd4, eerr:4'b1111, eovf:4'b0000};
    tbl[4] = '{sel:2'd2, r0:16'h9999, r1:16'h9999, r2:16'h9999, r3:16'h9999, fill:16'h9999,
               ex:50'd999999999999999, ey:50'd999999999999999,
               ez:50'd999999999999999, eb:50'd999999999999999, eerr:4'b0000, eovf:4'b0000};

    for (int r = 0; r < 16; r++) rom8[r] = 16'hFFFF;
    rom8[0] = 16'hFFF2;
    rom8[1] = 16'hFFF5;
    rom8[2] = 16'hFFF6;
    load_rom(tbl[0]);

    rst_n = 1'b0; start = 1'b0; card_sel = 2'd0; start8 = 1'b0; card_sel8 = 2'd0;
    seen_addr = 16'd0; mask_bad = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    chk("reset_slt_addr", {58'd0, card_slt, card_addr}, 64'd0);
    chk("reset_vals", 64'(val_x | val_y | val_z | val_b), 64'd0);
    chk("reset_flags", {55'd0, bad_sel, digit_err, ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      load_rom(tbl[i]);
      start_run(tbl[i]);
      wait_done($sformatf("vec%0d", i));
    end

    // Illegal select: bad_sel pulse only, nothing else moves
    @(negedge clk);
    prev_addr = card_addr;
    card_sel = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("bad_sel_pulse", {63'd0, bad_sel}, 64'd1);
    chk("bad_sel_busy_done", {62'd0, busy, done}, 64'd0);
    chk("bad_sel_addr", 64'(card_addr), 64'(prev_addr));
    @(posedge clk);
    #1;
    chk("bad_sel_one_cycle", {62'd0, bad_sel, busy}, 64'd0);

    // start during the run and during DONE is ignored
    load_rom(tbl[0]);
    start_run(tbl[0]);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      start = (k == 10 || k == 31);
      card_sel = 2'd2;
      @(posedge clk);
      #1;
      if (k == 11) chk("restart_busy", {63'd0, busy}, 64'd1);
      if (k == 11) chk("restart_slt", 64'(card_slt), 64'd1);
    end
    start = 1'b0;
    chk("restart_done_seen", 64'(sbq.size()), 64'd0);
    chk("start_in_done_ignored", {63'd0, busy}, 64'd0);

    // Reset mid-conversion: abandoned run, then a clean one
    load_rom(tbl[0]);
    @(negedge clk);
    card_sel = 2'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("midrst_busy_done", {62'd0, busy, done}, 64'd0);
      chk("midrst_slt_addr", {58'd0, card_slt, card_addr}, 64'd0);
      chk("midrst_vals", 64'(val_x | val_y | val_z | val_b), 64'd0);
      chk("midrst_flags", {55'd0, bad_sel, digit_err, ovf}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    load_rom(tbl[2]);
    start_run(tbl[2]);
    wait_done("post_reset");

    // Narrow accumulator: B digits 2,5,6 give 256, which wraps to 0 in 8 bits
    @(negedge clk);
    card_sel8 = 2'd1;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    k8 = 0;
    while (done8 !== 1'b1 && k8 < 60) begin
      @(posedge clk);
      #1;
      k8++;
    end
    chk("w8_latency", 64'(k8), 64'd31);
    chk("w8_val_b", 64'(val_b8), 64'd0);
    chk("w8_ovf", 64'(ovf8), 64'b0001);
    chk("w8_other_vals", 64'(val_x8 | val_y8 | val_z8), 64'd0);
    chk("w8_digit_err", 64'(digit_err8), 64'd0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
